// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial borrow subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell: d = a - b - bin, bout = borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - W-bit LSB-first serial subtractor with start/busy/done handshake
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_borrow_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    count_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic             b_out_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic d_bit;
  logic bout_bit;
  logic last_bit;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (count_q == CW'(WIDTH - 1));

  // After WIDTH-1 right shifts the operand registers present the original MSBs at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      b_out_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            borrow_q <= b_in;
            count_q  <= '0;
            diff_q   <= '0;
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          borrow_q <= bout_bit;
          if (last_bit) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            b_out_q <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= (a_sr_q[0] ^ b_sr_q[0]) & (a_sr_q[0] ^ d_bit);
`endif
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb/tb_serial_borrow_subtractor.sv - directed self-checking bench for serial_borrow_subtractor
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #22;
    n_checks++;
    if ({busy, done, diff, b_out} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual busy=%b done=%b diff=%h b_out=%b required all 0", busy, done, diff, b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start at edge k; done expected on the sample after edge k+W, i.e. loop index W+1.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] ediff, input logic ebout,
                        input bit chk_ovf, input logic eovf, input string name);
    int  lat;
    bit  got;
    @(negedge clk);
    a = ta; b = tb_; b_in = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_; b_in = ~tbin;
    lat = 0; got = 1'b0;
    for (int i = 1; i <= W + 3 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end else begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_busy: cycle %0d actual busy=%b required 1", name, i, busy);
        end
      end
    end
    n_checks++;
    if (!got || lat != W + 1) begin
      n_fail++;
      $display("FAIL %s_latency: actual %0d required %0d (got=%0b)", name, lat, W + 1, got);
    end
    n_checks++;
    if (diff !== ediff || b_out !== ebout) begin
      n_fail++;
      $display("FAIL %s_result: actual diff=%h b_out=%b required diff=%h b_out=%b", name, diff, b_out, ediff, ebout);
    end
`ifdef SERIAL_SUB_OVF_EN
    if (chk_ovf) begin
      n_checks++;
      if (ovf !== eovf) begin
        n_fail++;
        $display("FAIL %s_ovf: actual %b required %b", name, ovf, eovf);
      end
    end
`endif
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== ediff || b_out !== ebout) begin
      n_fail++;
      $display("FAIL %s_after: actual done=%b busy=%b diff=%h b_out=%b required done=0 busy=0 diff=%h b_out=%b",
               name, done, busy, diff, b_out, ediff, ebout);
    end
  endtask

  task automatic test_basic();
    run_op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, "sub_9_3");
    run_op(4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, "sub_3_9");
    run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, "sub_0_0_bin");
    run_op(4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "sub_F_0");
    run_op(4'h5, 4'h5, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, "sub_5_5_bin");
    run_op(4'hA, 4'h3, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, "sub_A_3_bin");
  endtask

  task automatic test_ovf();
    run_op(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, "ovf_8_1");
    run_op(4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 1'b1, "ovf_7_F");
  endtask

  task automatic test_ignored_start();
    int   pulses;
    logic [W-1:0] rdiff;
    logic rbout;
    pulses = 0; rdiff = '0; rbout = 1'b0;
    @(negedge clk);
    a = 4'h9; b = 4'h3; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 4'h1; b = 4'h1; b_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        rdiff = diff;
        rbout = b_out;
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL ignored_start_pulses: actual %0d required 1", pulses);
    end
    n_checks++;
    if (rdiff !== 4'h6 || rbout !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_result: actual diff=%h b_out=%b required diff=6 b_out=0", rdiff, rbout);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    a = 4'h9; b = 4'h3; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, b_out} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: actual busy=%b done=%b diff=%h b_out=%b required all 0", busy, done, diff, b_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: actual pulses=%0d busy=%b required pulses=0 busy=0", pulses, busy);
    end
    run_op(4'hC, 4'h5, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int   t1, t2;
    logic [W-1:0] d1, d2;
    logic o1, o2;
    t1 = -1; t2 = -1; d1 = '0; d2 = '0; o1 = 1'b0; o2 = 1'b0;
    @(negedge clk);
    a = 4'h9; b = 4'h3; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 4'h5; b = 4'h7;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (t1 < 0) begin
          t1 = j; d1 = diff; o1 = b_out;
        end else if (t2 < 0) begin
          t2 = j; d2 = diff; o2 = b_out;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (t1 != W + 1 || t2 != 2 * W + 3) begin
      n_fail++;
      $display("FAIL b2b_timing: actual done at %0d,%0d required %0d,%0d", t1, t2, W + 1, 2 * W + 3);
    end
    n_checks++;
    if (d1 !== 4'h6 || o1 !== 1'b0 || d2 !== 4'hE || o2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_results: actual %h/%b %h/%b required 6/0 e/1", d1, o1, d2, o2);
    end
    repeat (2 * W + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
